// File: rtl/button_event_pkg.sv
// Shared definitions for the button event classifier: FSM state encoding
// and small constant helpers used to size counters.
package button_event_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        GAP    = 3'd2,
        PRESS2 = 3'd3,
        HOLD   = 3'd4
    } state_t;

    // Bits needed to hold values 0..value-1 (at least 1).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        for (int unsigned v = value - 1; v != 0; v = v >> 1) begin
            width++;
        end
        return (width == 0) ? 1 : width;
    endfunction

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/button_tick_gen.sv
// Free-running timebase: pulses tick for the one cycle in which the
// 0..TICK_DIV-1 counter wraps.
module button_tick_gen
    import button_event_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned TW = clog2(TICK_DIV);
    localparam logic [TW-1:0] LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0] count;

    // Wrapping divide-by-TICK_DIV counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/button_press_classifier.sv
// Turns the debounced button level into single, double, long and
// auto-repeat events. Event outputs are registered one-cycle pulses.
module button_press_classifier
    import button_event_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 50000,
    parameter int unsigned LONG_MS    = 800,
    parameter int unsigned DOUBLE_MS  = 250,
    parameter int unsigned REPEAT_MS  = 150,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic       Classify_CLOCK_50,
    input  logic       Classify_Reset_InLow,
    input  logic       Classify_Button_In,
    output logic       Classify_Short_Out,
    output logic       Classify_Double_Out,
    output logic       Classify_Long_Out,
    output logic       Classify_Repeat_Out,
    output logic       Classify_Held_Out,
    output logic [2:0] Classify_State_Out
);

    localparam int unsigned CW = clog2(max3(LONG_MS, DOUBLE_MS, REPEAT_MS) + 1);
    localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_MS - 1);
    localparam logic [CW-1:0] DOUBLE_LAST = CW'(DOUBLE_MS - 1);
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_MS - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          tick;
    logic          p, prev;
    logic          press_edge, release_edge;
    logic          long_hit, double_hit, repeat_hit;
    logic          short_nxt, double_nxt, long_nxt, repeat_nxt;

    button_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk  (Classify_CLOCK_50),
        .rst_n(Classify_Reset_InLow),
        .tick (tick)
    );

    assign p            = Classify_Button_In ^ ACTIVE_LOW;
    assign press_edge   = p & ~prev;
    assign release_edge = ~p & prev;
    assign long_hit     = tick && (cnt == LONG_LAST);
    assign double_hit   = tick && (cnt == DOUBLE_LAST);
    assign repeat_hit   = (REPEAT_MS != 0) && tick && (cnt == REPEAT_LAST);

    // Previous pressed level; resets to "pressed" so a button held through
    // reset must be released before it can generate an event.
    always_ff @(posedge Classify_CLOCK_50 or negedge Classify_Reset_InLow) begin
        if (!Classify_Reset_InLow) prev <= 1'b1;
        else                       prev <= p;
    end

    // State register.
    always_ff @(posedge Classify_CLOCK_50 or negedge Classify_Reset_InLow) begin
        if (!Classify_Reset_InLow) state <= IDLE;
        else                       state <= state_nxt;
    end

    // Next-state and event decode; edges take priority over thresholds.
    always_comb begin
        state_nxt  = state;
        short_nxt  = 1'b0;
        double_nxt = 1'b0;
        long_nxt   = 1'b0;
        repeat_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (press_edge) state_nxt = PRESS1;
            end
            PRESS1: begin
                if (release_edge) begin
                    state_nxt = GAP;
                end else if (long_hit) begin
                    long_nxt  = 1'b1;
                    state_nxt = HOLD;
                end
            end
            GAP: begin
                if (press_edge) begin
                    state_nxt = PRESS2;
                end else if (double_hit) begin
                    short_nxt = 1'b1;
                    state_nxt = IDLE;
                end
            end
            PRESS2: begin
                if (release_edge) begin
                    double_nxt = 1'b1;
                    state_nxt  = IDLE;
                end else if (long_hit) begin
                    double_nxt = 1'b1;
                    state_nxt  = HOLD;
                end
            end
            HOLD: begin
                if (release_edge) state_nxt = IDLE;
                else if (repeat_hit) repeat_nxt = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Millisecond counter: restarts on any state change or repeat, else
    // counts ticks and saturates.
    always_ff @(posedge Classify_CLOCK_50 or negedge Classify_Reset_InLow) begin
        if (!Classify_Reset_InLow) begin
            cnt <= '0;
        end else if ((state_nxt != state) || repeat_nxt) begin
            cnt <= '0;
        end else if (tick && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Registered one-cycle event pulses.
    always_ff @(posedge Classify_CLOCK_50 or negedge Classify_Reset_InLow) begin
        if (!Classify_Reset_InLow) begin
            Classify_Short_Out  <= 1'b0;
            Classify_Double_Out <= 1'b0;
            Classify_Long_Out   <= 1'b0;
            Classify_Repeat_Out <= 1'b0;
        end else begin
            Classify_Short_Out  <= short_nxt;
            Classify_Double_Out <= double_nxt;
            Classify_Long_Out   <= long_nxt;
            Classify_Repeat_Out <= repeat_nxt;
        end
    end

    assign Classify_Held_Out  = (state == HOLD);
    assign Classify_State_Out = state;

endmodule
